spi_nor_responder: RTL and testbench

// SPI NOR flash responder that serves the card's flash-master boot path (firmware and image

---
 rtl/spi_nor_responder_pkg.sv | 47 ++++
 rtl/spi_nor_responder_sync.sv | 43 ++++
 rtl/spi_nor_responder.sv | 257 +++++++++++++++++++++++++
 tb/tb_spi_nor_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_nor_responder_pkg.sv
// ----------------------------------------------------------------------------
// spi_nor_responder_pkg
// Shared definitions for the SPI NOR flash responder: supported opcodes,
// the responder state encoding, the debug/observation struct and the
// opcode-to-state decode helper.
// ----------------------------------------------------------------------------
package spi_nor_responder_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_RDID  = 8'h9F;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    typedef enum logic [2:0] {
        ST_CMD    = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DUMMY  = 3'd2,
        ST_DATA   = 3'd3,
        ST_ID     = 3'd4,
        ST_STAT   = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    // Observation bundle: FSM state, bit counter and the synchronised pin
    // edges, so bring-up and checkers can see exactly what the core reacted to.
    typedef struct packed {
        state_t     state;
        logic [5:0] bit_cnt;
        logic       fck_rise;
        logic       fck_fall;
        logic       ncs_rise;
        logic       ncs_fall;
        logic       mosi_rise;
        logic       mosi_fall;
    } dbg_t;

    // State entered after the eighth command bit.
    function automatic state_t opcode_state(input logic [7:0] op);
        case (op)
            OP_READ, OP_FREAD: return ST_ADDR;
            OP_RDID:           return ST_ID;
            OP_RDSR:           return ST_STAT;
            default:           return ST_IGNORE;
        endcase
    endfunction

endpackage

// File: rtl/spi_nor_responder_sync.sv
// ----------------------------------------------------------------------------
// spi_pin_sync
// Multi-flop synchroniser for one asynchronous pin, followed by an edge
// detector on the synchronised level.
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-high reset (flops load RST_VAL)
//   pin_i    asynchronous pin
//   level_o  synchronised level (STAGES flops after pin_i)
//   rise_o   one-cycle pulse, synchronised level went 0 -> 1
//   fall_o   one-cycle pulse, synchronised level went 1 -> 0
// STAGES must be at least 2.
// ----------------------------------------------------------------------------
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= STAGES'({sync_q, pin_i});
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_nor_responder.sv
// ----------------------------------------------------------------------------
// spi_nor_responder
// SPI NOR flash stand-in for the flash-master boot path. Decodes mode-0
// opcodes (READ 03, FAST READ 0B, RDID 9F, RDSR 05) and serves read data from
// a fixed-latency byte memory port.
// Ports:
//   C25M     system clock, all logic on posedge
//   RES      asynchronous active-high reset
//   nFCS     chip select, active low, asynchronous
//   FCK      SPI clock (mode 0), asynchronous
//   MOSI     serial data in, MSB first
//   MISO     serial data out, MSB first
//   MISO_OE  MISO pad output enable
//   MemAddr  byte address to backing memory
//   MemRD    one-cycle read strobe
//   MemData  read data, valid MEM_LAT cycles after MemRD
//   Busy     high while selected (synchronised nFCS low)
//   Dbg      FSM state, bit counter and synchronised pin edges
// Memory port: MemRD is a single-cycle strobe with no back-pressure; MemData
// is sampled exactly MEM_LAT cycles later, whatever else is happening.
// ----------------------------------------------------------------------------
module spi_nor_responder
    import spi_nor_responder_pkg::*;
#(
    parameter int          MEM_LAT     = 2,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter logic [23:0] ADDR_MASK   = 24'hFFFFFF,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        C25M,
    input  logic        RES,
    input  logic        nFCS,
    input  logic        FCK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_OE,
    output logic [23:0] MemAddr,
    output logic        MemRD,
    input  logic [7:0]  MemData,
    output logic        Busy,
    output dbg_t        Dbg
);

    // ------------------------------------------------------------------
    // Pin synchronisers
    // ------------------------------------------------------------------
    logic ncs_lvl, ncs_rise, ncs_fall;
    logic fck_lvl, fck_rise, fck_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    // Chip select resets to the deselected level so Busy reads 0 in reset.
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk_i   (C25M),
        .rst_i   (RES),
        .pin_i   (nFCS),
        .level_o (ncs_lvl),
        .rise_o  (ncs_rise),
        .fall_o  (ncs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_fck (
        .clk_i   (C25M),
        .rst_i   (RES),
        .pin_i   (FCK),
        .level_o (fck_lvl),
        .rise_o  (fck_rise),
        .fall_o  (fck_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i   (C25M),
        .rst_i   (RES),
        .pin_i   (MOSI),
        .level_o (mosi_lvl),
        .rise_o  (mosi_rise),
        .fall_o  (mosi_fall)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_q,    state_d;
    logic [5:0]           bit_cnt_q,  bit_cnt_d;
    logic [7:0]           cmd_q,      cmd_d;
    logic [22:0]          addr_sr_q,  addr_sr_d;
    logic [7:0]           out_sr_q,   out_sr_d;
    logic [1:0]           id_idx_q,   id_idx_d;
    logic                 miso_q,     miso_d;
    logic                 oe_q,       oe_d;
    logic [23:0]          mem_addr_q, mem_addr_d;
    logic                 mem_rd_q,   mem_rd_d;
    logic [MEM_LAT-1:0]   rd_pipe_q,  rd_pipe_d;

    always_ff @(posedge C25M or posedge RES) begin
        if (RES) begin
            state_q    <= ST_CMD;
            bit_cnt_q  <= '0;
            cmd_q      <= '0;
            addr_sr_q  <= '0;
            out_sr_q   <= '0;
            id_idx_q   <= '0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            rd_pipe_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            cmd_q      <= cmd_d;
            addr_sr_q  <= addr_sr_d;
            out_sr_q   <= out_sr_d;
            id_idx_q   <= id_idx_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            rd_pipe_q  <= rd_pipe_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_d      = cmd_q;
        addr_sr_d  = addr_sr_q;
        out_sr_d   = out_sr_q;
        id_idx_d   = id_idx_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        rd_pipe_d  = MEM_LAT'({rd_pipe_q, mem_rd_q});

        // Fetched byte lands in the shift register; the FCK timing limits
        // guarantee this happens between a rise and the following fall.
        if (rd_pipe_q[MEM_LAT-1]) begin
            out_sr_d = MemData;
        end

        if (ncs_lvl) begin
            // Deselect has priority over any FCK edge seen in the same cycle.
            state_d   = ST_CMD;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            miso_d    = 1'b0;
        end else if (fck_rise) begin
            case (state_q)
                ST_CMD: begin
                    cmd_d = {cmd_q[6:0], mosi_lvl};
                    if (bit_cnt_q == 6'd7) begin
                        bit_cnt_d = '0;
                        state_d   = opcode_state(cmd_d);
                        if (cmd_d == OP_RDID) begin
                            out_sr_d = JEDEC_ID[23:16];
                            id_idx_d = 2'd1;
                        end else if (cmd_d == OP_RDSR) begin
                            out_sr_d = 8'h00;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                ST_ADDR: begin
                    addr_sr_d = {addr_sr_q[21:0], mosi_lvl};
                    if (bit_cnt_q == 6'd23) begin
                        // Fetch immediately; for FAST READ the byte simply
                        // waits in the shift register through the dummy byte.
                        bit_cnt_d  = '0;
                        mem_addr_d = {addr_sr_q, mosi_lvl} & ADDR_MASK;
                        mem_rd_d   = 1'b1;
                        state_d    = (cmd_q == OP_FREAD) ? ST_DUMMY : ST_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                ST_DUMMY: begin
                    if (bit_cnt_q == 6'd7) begin
                        bit_cnt_d = '0;
                        state_d   = ST_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                ST_DATA: begin
                    // Master has taken bit 0: prefetch the next byte.
                    if (bit_cnt_q == 6'd7) begin
                        bit_cnt_d  = '0;
                        mem_addr_d = (mem_addr_q + 24'd1) & ADDR_MASK;
                        mem_rd_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                ST_ID: begin
                    if (bit_cnt_q == 6'd7) begin
                        bit_cnt_d = '0;
                        case (id_idx_q)
                            2'd1:    out_sr_d = JEDEC_ID[15:8];
                            2'd2:    out_sr_d = JEDEC_ID[7:0];
                            default: out_sr_d = 8'h00;
                        endcase
                        id_idx_d = (id_idx_q == 2'd3) ? 2'd3 : id_idx_q + 2'd1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                ST_STAT: begin
                    if (bit_cnt_q == 6'd7) begin
                        bit_cnt_d = '0;
                        out_sr_d  = 8'h00;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                default: begin
                    // ST_IGNORE: stay silent until deselect.
                end
            endcase
        end else if (fck_fall) begin
            if (state_q == ST_DATA || state_q == ST_ID || state_q == ST_STAT) begin
                miso_d   = out_sr_q[7];
                out_sr_d = {out_sr_q[6:0], 1'b0};
                oe_d     = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign MISO    = miso_q;
    assign MISO_OE = oe_q;
    assign MemAddr = mem_addr_q;
    assign MemRD   = mem_rd_q;
    assign Busy    = ~ncs_lvl;

    always_comb begin
        Dbg           = '0;
        Dbg.state     = state_q;
        Dbg.bit_cnt   = bit_cnt_q;
        Dbg.fck_rise  = fck_rise;
        Dbg.fck_fall  = fck_fall;
        Dbg.ncs_rise  = ncs_rise;
        Dbg.ncs_fall  = ncs_fall;
        Dbg.mosi_rise = mosi_rise;
        Dbg.mosi_fall = mosi_fall;
    end

    // FCK level itself is only consumed through its edges.
    logic unused_fck_lvl;
    assign unused_fck_lvl = fck_lvl;

endmodule

// File: tb/tb_spi_nor_responder.sv
// ----------------------------------------------------------------------------
// tb_spi_nor_responder
// Directed bench for spi_nor_responder. Backing memory returns
// MemAddr[7:0] ^ 8'h5A two cycles after the read strobe; FCK half-period is
// 6 C25M cycles.
// ----------------------------------------------------------------------------
module tb_spi_nor_responder;
    import spi_nor_responder_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        C25M = 1'b0;
    logic        RES;
    logic        nFCS;
    logic        FCK;
    logic        MOSI;
    logic        MISO;
    logic        MISO_OE;
    logic [23:0] MemAddr;
    logic        MemRD;
    logic [7:0]  MemData;
    logic        Busy;
    dbg_t        Dbg;

    always #5 C25M = ~C25M;

    spi_nor_responder dut (
        .C25M    (C25M),
        .RES     (RES),
        .nFCS    (nFCS),
        .FCK     (FCK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .MISO_OE (MISO_OE),
        .MemAddr (MemAddr),
        .MemRD   (MemRD),
        .MemData (MemData),
        .Busy    (Busy),
        .Dbg     (Dbg)
    );

    // ---------------- memory model (2-cycle latency) ----------------
    logic [7:0] mem_d1, mem_d2;
    always @(posedge C25M) begin
        mem_d1 <= MemAddr[7:0] ^ 8'h5A;
        mem_d2 <= mem_d1;
    end
    assign MemData = mem_d2;

    // ---------------- monitor / scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    int          rd_count = 0;
    logic        oe_seen = 1'b0;
    logic [23:0] rd_addr_q[$];
    logic [7:0]  exp_q[$];
    logic [23:0] exp_addr_q[$];

    always @(posedge C25M) begin
        if (MemRD) begin
            rd_count = rd_count + 1;
            rd_addr_q.push_back(MemAddr);
        end
        if (MISO_OE) oe_seen = 1'b1;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge C25M);
    endtask

    task automatic clear_mon();
        rd_count = 0;
        oe_seen  = 1'b0;
        rd_addr_q.delete();
    endtask

    // Mode 0: MOSI set while FCK low, MISO sampled just before the rise.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI = tx[7-i];
            tick(6);
            rx  = {rx[6:0], MISO};
            FCK = 1'b1;
            tick(6);
            FCK = 1'b0;
        end
    endtask

    task automatic select();
        nFCS = 1'b0;
        tick(6);
    endtask

    task automatic deselect();
        tick(6);
        nFCS = 1'b1;
        tick(10);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [23:0] addr);
        logic [7:0] rx;
        spi_bits(op, 8, rx);
        spi_bits(addr[23:16], 8, rx);
        spi_bits(addr[15:8], 8, rx);
        spi_bits(addr[7:0], 8, rx);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RES = 1'b1; nFCS = 1'b1; FCK = 1'b0; MOSI = 1'b0;
        tick(3);
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", MISO); end
        checks++; if (MISO_OE !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", MISO_OE); end
        checks++; if (MemAddr !== 24'h000000) begin errors++; $display("FAIL reset_addr: got %h want 000000", MemAddr); end
        checks++; if (MemRD !== 1'b0) begin errors++; $display("FAIL reset_memrd: got %b want 0", MemRD); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (Dbg.state !== ST_CMD) begin errors++; $display("FAIL reset_state: got %0d want %0d", Dbg.state, ST_CMD); end
        RES = 1'b0;
        tick(4);
    endtask

    task automatic test_read();
        logic [7:0] rx;
        clear_mon();
        exp_q = '{8'h6E, 8'h6F, 8'h6C, 8'h6D};
        exp_addr_q = '{24'h001234, 24'h001235, 24'h001236, 24'h001237, 24'h001238};
        select();
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL read_busy: got %b want 1", Busy); end
        send_cmd(OP_READ, 24'h001234);
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL read_oe_early: got %b want 0", oe_seen); end
        for (int i = 0; i < 4; i++) begin
            spi_bits(8'h00, 8, rx);
            checks++; if (rx !== exp_q[0]) begin errors++; $display("FAIL read_byte%0d: got %h want %h", i, rx, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        checks++; if (MISO_OE !== 1'b1) begin errors++; $display("FAIL read_oe: got %b want 1", MISO_OE); end
        deselect();
        checks++; if (MISO_OE !== 1'b0) begin errors++; $display("FAIL read_oe_desel: got %b want 0", MISO_OE); end
        checks++; if (rd_count !== 5) begin errors++; $display("FAIL read_rdcount: got %0d want 5", rd_count); end
        for (int i = 0; i < 5; i++) begin
            if (rd_addr_q.size() > 0) begin
                checks++; if (rd_addr_q[0] !== exp_addr_q[0]) begin errors++; $display("FAIL read_addr%0d: got %h want %h", i, rd_addr_q[0], exp_addr_q[0]); end
                void'(rd_addr_q.pop_front());
                void'(exp_addr_q.pop_front());
            end
        end
    endtask

    task automatic test_fast_read();
        logic [7:0] rx;
        clear_mon();
        exp_q = '{8'hA4, 8'hA5, 8'h5A};
        exp_addr_q = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
        select();
        send_cmd(OP_FREAD, 24'hFFFFFE);
        spi_bits(8'h00, 8, rx);
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL fast_oe_dummy: got %b want 0", oe_seen); end
        for (int i = 0; i < 3; i++) begin
            spi_bits(8'h00, 8, rx);
            checks++; if (rx !== exp_q[0]) begin errors++; $display("FAIL fast_byte%0d: got %h want %h", i, rx, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        deselect();
        checks++; if (rd_count !== 4) begin errors++; $display("FAIL fast_rdcount: got %0d want 4", rd_count); end
        for (int i = 0; i < 4; i++) begin
            if (rd_addr_q.size() > 0) begin
                checks++; if (rd_addr_q[0] !== exp_addr_q[0]) begin errors++; $display("FAIL fast_addr%0d: got %h want %h", i, rd_addr_q[0], exp_addr_q[0]); end
                void'(rd_addr_q.pop_front());
                void'(exp_addr_q.pop_front());
            end
        end
    endtask

    task automatic test_rdid();
        logic [7:0] rx;
        clear_mon();
        exp_q = '{8'hEF, 8'h40, 8'h18, 8'h00, 8'h00};
        select();
        spi_bits(OP_RDID, 8, rx);
        for (int i = 0; i < 5; i++) begin
            spi_bits(8'hFF, 8, rx);
            checks++; if (rx !== exp_q[0]) begin errors++; $display("FAIL rdid_byte%0d: got %h want %h", i, rx, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        deselect();
        checks++; if (rd_count !== 0) begin errors++; $display("FAIL rdid_rdcount: got %0d want 0", rd_count); end
    endtask

    task automatic test_status();
        logic [7:0] rx;
        clear_mon();
        select();
        spi_bits(OP_RDSR, 8, rx);
        for (int i = 0; i < 2; i++) begin
            spi_bits(8'hFF, 8, rx);
            checks++; if (rx !== 8'h00) begin errors++; $display("FAIL status_byte%0d: got %h want 00", i, rx); end
        end
        checks++; if (oe_seen !== 1'b1) begin errors++; $display("FAIL status_oe: got %b want 1", oe_seen); end
        deselect();
        checks++; if (rd_count !== 0) begin errors++; $display("FAIL status_rdcount: got %0d want 0", rd_count); end
    endtask

    task automatic test_ignore();
        logic [7:0] rx;
        clear_mon();
        select();
        spi_bits(8'hC7, 8, rx);
        spi_bits(8'hA5, 8, rx);
        spi_bits(8'h3C, 8, rx);
        checks++; if (Dbg.state !== ST_IGNORE) begin errors++; $display("FAIL ignore_state: got %0d want %0d", Dbg.state, ST_IGNORE); end
        deselect();
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL ignore_oe: got %b want 0", oe_seen); end
        checks++; if (rd_count !== 0) begin errors++; $display("FAIL ignore_rdcount: got %0d want 0", rd_count); end
        select();
        send_cmd(OP_READ, 24'h000000);
        spi_bits(8'h00, 8, rx);
        checks++; if (rx !== 8'h5A) begin errors++; $display("FAIL ignore_then_read: got %h want 5a", rx); end
        deselect();
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        clear_mon();
        select();
        spi_bits(OP_READ, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'hA0, 4, rx);
        nFCS = 1'b1;
        tick(4);
        checks++; if (Dbg.state !== ST_CMD) begin errors++; $display("FAIL abort_state: got %0d want %0d", Dbg.state, ST_CMD); end
        checks++; if (Dbg.bit_cnt !== 6'd0) begin errors++; $display("FAIL abort_bitcnt: got %0d want 0", Dbg.bit_cnt); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", Busy); end
        tick(6);
        checks++; if (rd_count !== 0) begin errors++; $display("FAIL abort_rdcount: got %0d want 0", rd_count); end
        select();
        send_cmd(OP_READ, 24'h000010);
        spi_bits(8'h00, 8, rx);
        checks++; if (rx !== 8'h4A) begin errors++; $display("FAIL abort_then_read: got %h want 4a", rx); end
        deselect();
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        clear_mon();
        select();
        send_cmd(OP_READ, 24'h000100);
        spi_bits(8'h00, 8, rx);
        checks++; if (rx !== 8'h5A) begin errors++; $display("FAIL resmid_byte0: got %h want 5a", rx); end
        spi_bits(8'h00, 3, rx);
        RES = 1'b1;
        #1;
        checks++; if (MISO_OE !== 1'b0) begin errors++; $display("FAIL resmid_oe: got %b want 0", MISO_OE); end
        checks++; if (MemRD !== 1'b0) begin errors++; $display("FAIL resmid_memrd: got %b want 0", MemRD); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL resmid_busy: got %b want 0", Busy); end
        checks++; if (MemAddr !== 24'h000000) begin errors++; $display("FAIL resmid_addr: got %h want 000000", MemAddr); end
        nFCS = 1'b1;
        FCK  = 1'b0;
        tick(3);
        RES = 1'b0;
        tick(4);
        select();
        send_cmd(OP_READ, 24'h000020);
        spi_bits(8'h00, 8, rx);
        checks++; if (rx !== 8'h7A) begin errors++; $display("FAIL resmid_read0: got %h want 7a", rx); end
        spi_bits(8'h00, 8, rx);
        checks++; if (rx !== 8'h7B) begin errors++; $display("FAIL resmid_read1: got %h want 7b", rx); end
        deselect();
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_read();
        test_fast_read();
        test_rdid();
        test_status();
        test_ignore();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
